// File: rtl/lb_timeout_slice.sv
`default_nettype none
// ============================================================================
// Module   : lb_timeout_slice
// Purpose  : Local-bus register slice with a downstream response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lb_timeout_slice #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 32,
  parameter int          STRB_W   = DATA_W / 8,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADC0DE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_waddr,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wen,
  output logic              s_wready,
  input  logic [ADDR_W-1:0] s_raddr,
  input  logic              s_ren,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_rvalid,
  output logic [ADDR_W-1:0] m_waddr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  output logic              m_wen,
  input  logic              m_wready,
  output logic [ADDR_W-1:0] m_raddr,
  output logic              m_ren,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rvalid,
  output logic              tmo_pulse,
  output logic [7:0]        tmo_cnt
);

  localparam logic              c_wdog_en   = (TIMEOUT != 0);
  localparam logic [7:0]        c_wdog_last = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] c_err_data  = DATA_W'(ERR_DATA);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_wdog;
  logic [DATA_W-1:0] r_rdata;
  logic              w_resp;
  logic              w_expire;

  // A response on the expiry edge takes priority over the watchdog.
  assign w_resp   = ((r_state == WR) && m_wready) || ((r_state == RD) && m_rvalid);
  assign w_expire = c_wdog_en && ((r_state == WR) || (r_state == RD)) &&
                    (r_wdog == c_wdog_last) && !w_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_wready    = 1'b0;
    m_wen       = 1'b0;
    m_ren       = 1'b0;
    s_rvalid    = 1'b0;
    s_rdata     = '0;
    case (r_state)
      IDLE: begin
        s_wready = 1'b1;
        if (s_wen) begin
          w_state_nxt = WR;
        end else if (s_ren) begin
          w_state_nxt = RD;
        end
      end
      WR: begin
        m_wen = 1'b1;
        if (m_wready || w_expire) begin
          w_state_nxt = IDLE;
        end
      end
      RD: begin
        m_ren = 1'b1;
        if (m_rvalid || w_expire) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        s_rvalid    = 1'b1;
        s_rdata     = r_rdata;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog    <= 8'd0;
      r_rdata   <= '0;
      m_waddr   <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
      m_raddr   <= '0;
      tmo_pulse <= 1'b0;
      tmo_cnt   <= 8'd0;
    end else begin
      // Every WR/RD entry comes from IDLE, so clearing here resets per transaction.
      if (r_state == IDLE) begin
        r_wdog <= 8'd0;
      end else if (((r_state == WR) || (r_state == RD)) && !w_resp) begin
        r_wdog <= r_wdog + 8'd1;
      end

      if ((r_state == IDLE) && s_wen) begin
        m_waddr <= s_waddr;
        m_wdata <= s_wdata;
        m_wstrb <= s_wstrb;
      end else if ((r_state == IDLE) && s_ren) begin
        m_raddr <= s_raddr;
      end

      if ((r_state == RD) && m_rvalid) begin
        r_rdata <= m_rdata;
      end else if ((r_state == RD) && w_expire) begin
        r_rdata <= c_err_data;
      end

      tmo_pulse <= w_expire;
      if (w_expire && (tmo_cnt != 8'hFF)) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lb_timeout_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_timeout_slice
// Purpose  : Directed vector table plus hand sequences for lb_timeout_slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lb_timeout_slice;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] s_waddr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wen = 1'b0;
  logic        s_wready;
  logic [15:0] s_raddr = '0;
  logic        s_ren = 1'b0;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic [15:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wen;
  logic        m_wready = 1'b0;
  logic [15:0] m_raddr;
  logic        m_ren;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic        tmo_pulse;
  logic [7:0]  tmo_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  lb_timeout_slice #(
    .ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT(16), .ERR_DATA(32'hDEADC0DE)
  ) dut (
    .clk(clk), .rst(rst),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wen(s_wen),
    .s_wready(s_wready), .s_raddr(s_raddr), .s_ren(s_ren),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wen(m_wen),
    .m_wready(m_wready), .m_raddr(m_raddr), .m_ren(m_ren),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .tmo_pulse(tmo_pulse), .tmo_cnt(tmo_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ren;
    logic [15:0] raddr;
    logic        wready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [4:0]  e_ctrl;   // {s_wready, m_wen, m_ren, s_rvalid, tmo_pulse}
    logic [31:0] e_rdata;
    logic [15:0] e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [15:0] e_raddr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int pulses;
    bit got;

    vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,
                5'b01000, 32'h0, 16'h0004, 32'hDEADBEEF, 4'hF, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 16'h0000, 1'b1, 1'b0, 32'h0,
                5'b10000, 32'h0, 16'h0004, 32'hDEADBEEF, 4'hF, 16'h0000};
    vecs[2] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 16'h0014, 1'b0, 1'b0, 32'h0,
                5'b00100, 32'h0, 16'h0004, 32'hDEADBEEF, 4'hF, 16'h0014};
    vecs[3] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 16'h0014, 1'b0, 1'b1, 32'hC0DEBABE,
                5'b00010, 32'hC0DEBABE, 16'h0004, 32'hDEADBEEF, 4'hF, 16'h0014};
    vecs[4] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,
                5'b10000, 32'h0, 16'h0004, 32'hDEADBEEF, 4'hF, 16'h0014};
    vecs[5] = '{1'b1, 16'h0020, 32'h11112222, 4'h3, 1'b1, 16'h0030, 1'b0, 1'b0, 32'h0,
                5'b01000, 32'h0, 16'h0020, 32'h11112222, 4'h3, 16'h0014};
    vecs[6] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 16'h0030, 1'b1, 1'b0, 32'h0,
                5'b10000, 32'h0, 16'h0020, 32'h11112222, 4'h3, 16'h0014};
    vecs[7] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 16'h0030, 1'b0, 1'b0, 32'h0,
                5'b00100, 32'h0, 16'h0020, 32'h11112222, 4'h3, 16'h0030};
    vecs[8] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b1, 16'h0030, 1'b0, 1'b1, 32'h55AA55AA,
                5'b00010, 32'h55AA55AA, 16'h0020, 32'h11112222, 4'h3, 16'h0030};
    vecs[9] = '{1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 32'h0,
                5'b10000, 32'h0, 16'h0020, 32'h11112222, 4'h3, 16'h0030};

    // Reset state
    #12;
    check("rst_ctrl", {s_wready, m_wen, m_ren, s_rvalid, tmo_pulse}, 5'b10000);
    check("rst_data", {s_rdata, m_waddr, m_wdata, m_wstrb, m_raddr, tmo_cnt}, '0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Vector table: single-cycle write, 1-cycle read, write/read collision
    for (int i = 0; i < 10; i++) begin
      s_wen = vecs[i].wen;     s_waddr = vecs[i].waddr; s_wdata = vecs[i].wdata;
      s_wstrb = vecs[i].wstrb; s_ren = vecs[i].ren;     s_raddr = vecs[i].raddr;
      m_wready = vecs[i].wready; m_rvalid = vecs[i].rvalid; m_rdata = vecs[i].rdata;
      tick();
      check($sformatf("vec%0d_ctrl", i), {s_wready, m_wen, m_ren, s_rvalid, tmo_pulse}, vecs[i].e_ctrl);
      check($sformatf("vec%0d_rdata", i), s_rdata, vecs[i].e_rdata);
      check($sformatf("vec%0d_mfields", i), {m_waddr, m_wdata, m_wstrb, m_raddr},
            {vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_wstrb, vecs[i].e_raddr});
    end
    s_ren = 1'b0; m_wready = 1'b0; m_rvalid = 1'b0;

    // Stalled write: m_wen held 6 cycles, second write waits
    s_wen = 1'b1; s_waddr = 16'h000C; s_wdata = 32'hCAFEBABE; s_wstrb = 4'h6;
    tick();
    s_waddr = 16'h0010; s_wdata = 32'h12345678; s_wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stall_c%0d_wen_wready", i), {m_wen, s_wready}, 2'b10);
      check($sformatf("stall_c%0d_fields", i), {m_waddr, m_wdata, m_wstrb},
            {16'h000C, 32'hCAFEBABE, 4'h6});
      if (i == 5) m_wready = 1'b1;
      tick();
    end
    check("stall_done", {m_wen, s_wready}, 2'b01);
    tick();
    s_wen = 1'b0;
    check("second_wr", {m_wen, m_waddr, m_wdata}, {1'b1, 16'h0010, 32'h12345678});
    tick();
    m_wready = 1'b0;
    check("second_wr_done", {m_wen, s_wready}, 2'b01);

    // Silent read -> timeout
    s_ren = 1'b1; s_raddr = 16'h0008;
    tick();
    cnt = 0; pulses = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (m_ren) cnt++;
      if (tmo_pulse) pulses++;
      if (s_rvalid) begin
        got = 1;
        check("rd_tmo_resp", {s_rdata, tmo_pulse, m_ren, tmo_cnt}, {32'hDEADC0DE, 1'b1, 1'b0, 8'd1});
        s_ren = 1'b0;
      end
      tick();
    end
    check("rd_tmo_got", got, 1'b1);
    check("rd_tmo_ren_cycles", cnt, 16);
    check("rd_tmo_pulses", pulses, 1);
    check("rd_tmo_after", {tmo_pulse, s_rvalid, s_rdata, tmo_cnt}, {1'b0, 1'b0, 32'h0, 8'd1});

    // Silent write -> timeout
    s_wen = 1'b1; s_waddr = 16'h0018; s_wdata = 32'hAAAA5555; s_wstrb = 4'hF;
    tick();
    s_wen = 1'b0;
    cnt = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (m_wen) cnt++;
      if (tmo_pulse) begin
        got = 1;
        check("wr_tmo_resp", {s_wready, m_wen, tmo_cnt}, {1'b1, 1'b0, 8'd2});
      end
      tick();
    end
    check("wr_tmo_got", got, 1'b1);
    check("wr_tmo_wen_cycles", cnt, 16);
    check("wr_tmo_after", {tmo_pulse, tmo_cnt}, {1'b0, 8'd2});

    // Response on the expiry edge wins
    s_ren = 1'b1; s_raddr = 16'h001C;
    tick();
    cnt = 0; pulses = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (tmo_pulse) pulses++;
      if (m_ren) begin
        cnt++;
        if (cnt == 16) begin m_rvalid = 1'b1; m_rdata = 32'h600DF00D; end
      end
      if (s_rvalid) begin
        got = 1;
        check("edge_resp", {s_rdata, tmo_pulse, tmo_cnt}, {32'h600DF00D, 1'b0, 8'd2});
        s_ren = 1'b0; m_rvalid = 1'b0;
      end
      tick();
    end
    check("edge_got", got, 1'b1);
    check("edge_ren_cycles", cnt, 16);
    check("edge_pulses", {pulses, tmo_pulse, tmo_cnt}, {32'd0, 1'b0, 8'd2});

    // Reset mid-read
    s_ren = 1'b1; s_raddr = 16'h0024;
    tick(); tick(); tick();
    check("pre_rst_ren", m_ren, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("async_rst", {m_ren, s_rvalid, tmo_cnt, s_wready}, {1'b0, 1'b0, 8'd0, 1'b1});
    s_ren = 1'b0;
    tick();
    rst = 1'b1;
    s_ren = 1'b1; s_raddr = 16'h0014;
    tick();
    check("post_rst_rd", {m_ren, m_raddr}, {1'b1, 16'h0014});
    m_rvalid = 1'b1; m_rdata = 32'hC0DEBABE;
    tick();
    check("post_rst_resp", {s_rvalid, s_rdata, m_ren, tmo_pulse}, {1'b1, 32'hC0DEBABE, 1'b0, 1'b0});
    s_ren = 1'b0; m_rvalid = 1'b0;
    tick();
    check("post_rst_idle", {s_rvalid, s_rdata, s_wready}, {1'b0, 32'h0, 1'b1});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lb_timeout_slice.md
# lb_timeout_slice

Local-bus register slice with a response watchdog. It sits between a bus-to-LB bridge (APB/AXI-Lite/Avalon) on the upstream side and the generated register map on the downstream side. It registers every write and read request, holds it to the register map until the map responds, and completes the transaction with a fixed error pattern if the map stays silent for too long. This breaks the bridge-to-regmap timing path and guarantees the host bus can never hang.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width (multiple of 8)
- STRB_W, DATA_W/8, byte-strobe width
- TIMEOUT, 16, max downstream wait in cycles (2..255); 0 disables the watchdog
- ERR_DATA, 32'hDEADC0DE, read data returned on timeout (truncated/zero-extended to DATA_W)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- s_waddr/s_wdata/s_wstrb  in  ADDR_W/DATA_W/STRB_W  upstream write request
- s_wen  in  1  upstream write request valid
- s_wready  out  1  write accepted when s_wen && s_wready
- s_raddr  in  ADDR_W  upstream read address
- s_ren  in  1  upstream read request, held until s_rvalid
- s_rdata  out  DATA_W  read data, valid with s_rvalid
- s_rvalid  out  1  one-cycle read response
- m_waddr/m_wdata/m_wstrb  out  ADDR_W/DATA_W/STRB_W  registered write request
- m_wen  out  1  downstream write valid, held until m_wready
- m_wready  in  1  downstream write accept
- m_raddr  out  ADDR_W  registered read address
- m_ren  out  1  downstream read request, held until m_rvalid
- m_rdata  in  DATA_W  downstream read data
- m_rvalid  in  1  downstream read response
- tmo_pulse  out  1  one-cycle pulse on any timeout
- tmo_cnt  out  8  saturating count of timeouts (stays at 255)

## Operation
- FSM states: IDLE, WR, RD, RESP.
- IDLE:
  - s_wready = 1 (combinational from state); all other outputs 0.
  - s_wen: capture waddr/wdata/wstrb -> WR.
  - else s_ren: capture raddr -> RD.
  - Both asserted: write wins; the read is taken on a later IDLE visit.
- WR: m_wen = 1 with the captured fields.
  - Edge with m_wready = 1 -> IDLE.
  - Watchdog expiry -> IDLE; the write is dropped, tmo_pulse fires.
- RD: m_ren = 1 with the captured address.
  - Edge with m_rvalid = 1: capture m_rdata -> RESP.
  - Expiry: load ERR_DATA -> RESP, tmo_pulse fires.
- RESP: s_rvalid = 1 for exactly one cycle, s_rdata = the captured value -> IDLE. s_rdata is 0 outside RESP.
- Upstream contract: s_ren is low in the cycle after s_rvalid. Upstream fields are sampled only at the acceptance edge.
- Watchdog:
  - 8-bit counter, cleared on entry to WR/RD, +1 per cycle with no response.
  - Expiry at the edge where the counter equals TIMEOUT-1 and no response is present, i.e. m_wen/m_ren are high for at most TIMEOUT cycles.
  - A response arriving on the expiry edge wins: normal completion, no pulse.
  - TIMEOUT = 0: never expires.
- tmo_cnt increments with each tmo_pulse and saturates at 255.
- m_* fields hold their last captured value outside WR/RD; only m_wen/m_ren qualify them.

## Timing
- Reset values:
  - state IDLE, so s_wready = 1 during and after reset.
  - m_wen, m_ren, s_rvalid, tmo_pulse = 0.
  - s_rdata, m_waddr, m_wdata, m_wstrb, m_raddr = 0.
  - tmo_cnt = 0.
- Write:
  - Accept edge N; m_wen high from cycle N+1.
  - m_wready at edge M -> s_wready high in cycle M+1.
  - Minimum 2 cycles per write.
- Read:
  - s_ren sampled at edge N; m_ren high from cycle N+1.
  - m_rvalid at edge M -> m_ren low and s_rvalid high in cycle M+1.
  - Slice adds 2 cycles to downstream latency.
- Timeout: tmo_pulse is high in the cycle after the expiry edge (same cycle s_rvalid rises for a read).
- Reset asserted mid-transaction: all outputs drop asynchronously, the transaction is lost, FSM returns to IDLE, tmo_cnt clears.

## Test plan
- Write 0x004/0xDEADBEEF, strb 0xF, m_wready tied 1 -> m_wen high exactly 1 cycle with m_waddr 0x004, m_wdata 0xDEADBEEF, m_wstrb 0xF; s_wready low that cycle only.
- Write 0x00C/0xCAFEBABE strb 0x6, m_wready low 5 cycles -> m_wen held 6 cycles with stable fields; second s_wen stalls (s_wready 0) until completion.
- Read 0x014, m_rvalid after 1 cycle with 0xC0DEBABE -> s_rvalid one cycle with 0xC0DEBABE, m_ren low same cycle, s_rdata 0 afterward.
- Read 0x008, downstream silent, TIMEOUT = 16 -> m_ren high exactly 16 cycles; s_rvalid with 0xDEADC0DE; tmo_pulse once; tmo_cnt = 1. Repeat as a silent write -> m_wen 16 cycles, tmo_cnt = 2.
- m_rvalid on the 16th cycle of m_ren -> normal data returned, no tmo_pulse. s_wen and s_ren both asserted from IDLE -> write serviced first, then the read.
- Assert rst during RD with m_ren high -> m_ren, s_rvalid and tmo_cnt drop to 0 immediately; after release a fresh read of 0x014 completes normally.
